// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX register that decodes MIPS opcode/funct and drives the ALU op/operand interface.
// Optional issue/illegal statistics counters are enabled by defining ALU_ISSUE_STATS_EN.
module alu_issue_stage #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [5:0]    in_opcode,
  input  logic [5:0]    in_funct,
  input  logic [DW-1:0] in_rs,
  input  logic [DW-1:0] in_rt,
  input  logic [15:0]   in_imm,
  input  logic          stall,
  input  logic          flush,
  output logic [2:0]    alu_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic          out_valid,
  output logic          illegal
`ifdef ALU_ISSUE_STATS_EN
  ,output logic [31:0]  issue_count,
  output logic [15:0]   illegal_count
`endif
);

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } alu_op_e;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ADDIU = 6'b001001;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;

  alu_op_e       dec_op;
  logic [DW-1:0] dec_a;
  logic [DW-1:0] dec_b;
  logic [DW-1:0] opnd_b;
  logic          dec_illegal;
  logic [DW-1:0] imm_sx;
  logic [DW-1:0] imm_zx;
  logic          load_en;

  assign imm_sx  = DW'($signed(in_imm));
  assign imm_zx  = DW'(in_imm);
  assign load_en = !flush && !stall && in_valid;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    dec_op      = OP_AND;
    opnd_b      = '0;
    dec_illegal = 1'b0;
    case (in_opcode)
      OPC_RTYPE: begin
        opnd_b = in_rt;
        case (in_funct)
          6'b100100:            dec_op = OP_AND;
          6'b100101:            dec_op = OP_OR;
          6'b100000, 6'b100001: dec_op = OP_ADD;
          6'b100010, 6'b100011: dec_op = OP_SUB;
          6'b101010:            dec_op = OP_SLT;
          default:              dec_illegal = 1'b1;
        endcase
      end
      OPC_ADDI, OPC_ADDIU, OPC_LW, OPC_SW: begin
        dec_op = OP_ADD;
        opnd_b = imm_sx;
      end
      OPC_SLTI: begin
        dec_op = OP_SLT;
        opnd_b = imm_sx;
      end
      OPC_ANDI: begin
        dec_op = OP_AND;
        opnd_b = imm_zx;
      end
      OPC_ORI: begin
        dec_op = OP_OR;
        opnd_b = imm_zx;
      end
      OPC_BEQ, OPC_BNE: begin
        dec_op = OP_SUB;
        opnd_b = in_rt;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // An unrecognised encoding travels with zeroed operands so nothing stale reaches the ALU.
  assign dec_a = dec_illegal ? '0 : in_rs;
  assign dec_b = dec_illegal ? '0 : opnd_b;

  // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_op    <= OP_AND;
      alu_a     <= '0;
      alu_b     <= '0;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
    end else if (flush || (!stall && !in_valid)) begin
      alu_op    <= OP_AND;
      alu_a     <= '0;
      alu_b     <= '0;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
    end else if (!stall) begin
      alu_op    <= dec_op;
      alu_a     <= dec_a;
      alu_b     <= dec_b;
      out_valid <= 1'b1;
      illegal   <= dec_illegal;
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_count   <= '0;
      illegal_count <= '0;
    end else if (load_en) begin
      if (dec_illegal) illegal_count <= illegal_count + 16'd1;
      else             issue_count   <= issue_count + 32'd1;
    end
  end
`else
  logic unused_load_en;
  assign unused_load_en = load_en;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed and randomized checks of alu_issue_stage against a behavioural model.
// Counter checks are compiled in when ALU_ISSUE_STATS_EN is defined.
module tb_alu_issue_stage;

  localparam int DW = 32;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        v;
    logic        ill;
  } out_t;

  localparam out_t BUBBLE = '0;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [5:0]    in_opcode;
  logic [5:0]    in_funct;
  logic [DW-1:0] in_rs;
  logic [DW-1:0] in_rt;
  logic [15:0]   in_imm;
  logic          stall;
  logic          flush;
  logic [2:0]    alu_op;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic          out_valid;
  logic          illegal;
`ifdef ALU_ISSUE_STATS_EN
  logic [31:0]   issue_count;
  logic [15:0]   illegal_count;
`endif

  int   checks = 0;
  int   errors = 0;
  out_t exp_q  = BUBBLE;
  int   n_iss  = 0;
  int   n_ill  = 0;

  alu_issue_stage #(.DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_opcode (in_opcode),
    .in_funct  (in_funct),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_imm    (in_imm),
    .stall     (stall),
    .flush     (flush),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .out_valid (out_valid),
    .illegal   (illegal)
`ifdef ALU_ISSUE_STATS_EN
    ,.issue_count   (issue_count),
    .illegal_count (illegal_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t observed();
    observed = {alu_op, alu_a, alu_b, out_valid, illegal};
  endfunction

  // Reference decode straight from the instruction table: op name and B-source per encoding.
  function automatic out_t ref_decode(input logic [5:0] opc, input logic [5:0] fn,
                                      input logic [31:0] rs, input logic [31:0] rt,
                                      input logic [15:0] imm);
    out_t r;
    int   simm;
    logic [31:0] sx;
    logic [31:0] zx;
    simm = (imm >= 16'h8000) ? int'(imm) - 65536 : int'(imm);
    sx   = 32'(simm);
    zx   = {16'h0000, imm};
    r    = '{op: 3'b000, a: rs, b: 32'h0, v: 1'b1, ill: 1'b0};
    case (opc)
      6'd0: begin
        r.b = rt;
        case (fn)
          6'h24:        r.op = 3'b000;
          6'h25:        r.op = 3'b001;
          6'h20, 6'h21: r.op = 3'b010;
          6'h22, 6'h23: r.op = 3'b110;
          6'h2A:        r.op = 3'b111;
          default:      r.ill = 1'b1;
        endcase
      end
      6'd8, 6'd9, 6'd35, 6'd43: begin r.op = 3'b010; r.b = sx; end
      6'd10:                    begin r.op = 3'b111; r.b = sx; end
      6'd12:                    begin r.op = 3'b000; r.b = zx; end
      6'd13:                    begin r.op = 3'b001; r.b = zx; end
      6'd4, 6'd5:               begin r.op = 3'b110; r.b = rt; end
      default:                  r.ill = 1'b1;
    endcase
    if (r.ill) r = '{op: 3'b000, a: 32'h0, b: 32'h0, v: 1'b1, ill: 1'b1};
    return r;
  endfunction

  // Drives one cycle of inputs, waits for the edge, applies flush > stall > load to the model.
  task automatic cycle(input logic v, input logic [5:0] opc, input logic [5:0] fn,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                       input logic st, input logic fl);
    in_valid = v; in_opcode = opc; in_funct = fn;
    in_rs = rs; in_rt = rt; in_imm = imm; stall = st; flush = fl;
    @(posedge clk);
    if (fl) exp_q = BUBBLE;
    else if (!st) begin
      if (v) begin
        exp_q = ref_decode(opc, fn, rs, rt, imm);
        if (exp_q.ill) n_ill++;
        else n_iss++;
      end else exp_q = BUBBLE;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle(1'b0, 6'd0, 6'd0, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    exp_q = BUBBLE; n_iss = 0; n_ill = 0;
  endtask

  task automatic test_reset();
    do_reset();
    cycle(1'b1, 6'd0, 6'h20, 32'd5, 32'd6, 16'd0, 1'b0, 1'b0);
    checks++;
    if (observed() !== ref_decode(6'd0, 6'h20, 32'd5, 32'd6, 16'd0)) begin
      errors++; $display("FAIL reset_preload obs=%h exp=%h", observed(), exp_q);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (observed() !== BUBBLE) begin
      errors++; $display("FAIL reset_async obs=%h exp=%h", observed(), BUBBLE);
    end
    @(posedge clk); #1;
    checks++;
    if (observed() !== BUBBLE) begin
      errors++; $display("FAIL reset_held obs=%h exp=%h", observed(), BUBBLE);
    end
`ifdef ALU_ISSUE_STATS_EN
    checks++;
    if (issue_count !== 32'd0 || illegal_count !== 16'd0) begin
      errors++; $display("FAIL reset_counts issue=%0d illegal=%0d exp=0/0", issue_count, illegal_count);
    end
`endif
    in_valid = 1'b0;
    #2 reset = 1'b0;
    exp_q = BUBBLE; n_iss = 0; n_ill = 0;
    cycle(1'b0, 6'd0, 6'h20, 32'd5, 32'd6, 16'd0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || observed() !== BUBBLE) begin
      errors++; $display("FAIL reset_idle obs=%h exp=%h", observed(), BUBBLE);
    end
  endtask

  task automatic test_rtype_sub();
    cycle(1'b1, 6'b000000, 6'b100010, 32'd11, 32'd7, 16'h1234, 1'b0, 1'b0);
    checks++;
    if (observed() !== {3'b110, 32'd11, 32'd7, 1'b1, 1'b0}) begin
      errors++; $display("FAIL rtype_sub obs=%h exp=%h", observed(), {3'b110, 32'd11, 32'd7, 1'b1, 1'b0});
    end
  endtask

  task automatic test_extensions();
    cycle(1'b1, 6'b001000, 6'd0, 32'h10, 32'h99, 16'hFFFF, 1'b0, 1'b0);
    checks++;
    if (observed() !== {3'b010, 32'h10, 32'hFFFFFFFF, 1'b1, 1'b0}) begin
      errors++; $display("FAIL ext_addi obs=%h", observed());
    end
    cycle(1'b1, 6'b001101, 6'd0, 32'h10, 32'h99, 16'hFFFF, 1'b0, 1'b0);
    checks++;
    if (observed() !== {3'b001, 32'h10, 32'h0000FFFF, 1'b1, 1'b0}) begin
      errors++; $display("FAIL ext_ori obs=%h", observed());
    end
    cycle(1'b1, 6'b001010, 6'd0, 32'h10, 32'h99, 16'hFFFF, 1'b0, 1'b0);
    checks++;
    if (observed() !== {3'b111, 32'h10, 32'hFFFFFFFF, 1'b1, 1'b0}) begin
      errors++; $display("FAIL ext_slti obs=%h", observed());
    end
    cycle(1'b1, 6'b001100, 6'd0, 32'h10, 32'h99, 16'h8001, 1'b0, 1'b0);
    checks++;
    if (observed() !== {3'b000, 32'h10, 32'h00008001, 1'b1, 1'b0}) begin
      errors++; $display("FAIL ext_andi obs=%h", observed());
    end
    cycle(1'b1, 6'b101011, 6'd0, 32'h10, 32'h99, 16'h7FFF, 1'b0, 1'b0);
    checks++;
    if (observed() !== {3'b010, 32'h10, 32'h00007FFF, 1'b1, 1'b0}) begin
      errors++; $display("FAIL ext_sw obs=%h", observed());
    end
  endtask

  task automatic test_stall();
    cycle(1'b1, 6'd0, 6'b100100, 32'hA5A5_0001, 32'h0F0F_0002, 16'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 6'd0, 6'b100101, $urandom, $urandom, 16'($urandom), 1'b1, 1'b0);
      checks++;
      if (observed() !== {3'b000, 32'hA5A5_0001, 32'h0F0F_0002, 1'b1, 1'b0}) begin
        errors++; $display("FAIL stall_hold_%0d obs=%h", i, observed());
      end
    end
    cycle(1'b1, 6'd0, 6'b100101, 32'd3, 32'd4, 16'd0, 1'b0, 1'b0);
    checks++;
    if (observed() !== {3'b001, 32'd3, 32'd4, 1'b1, 1'b0}) begin
      errors++; $display("FAIL stall_release obs=%h", observed());
    end
  endtask

  task automatic test_flush();
    cycle(1'b1, 6'd0, 6'b101010, 32'd9, 32'd8, 16'd0, 1'b0, 1'b0);
    cycle(1'b1, 6'd0, 6'b100000, 32'd1, 32'd2, 16'd0, 1'b1, 1'b1);
    checks++;
    if (observed() !== BUBBLE) begin
      errors++; $display("FAIL flush_priority obs=%h exp=%h", observed(), BUBBLE);
    end
  endtask

  task automatic test_illegal_stats();
    do_reset();
    cycle(1'b1, 6'b111111, 6'd0, 32'd77, 32'd88, 16'h1234, 1'b0, 1'b0);
    checks++;
    if (observed() !== {3'b000, 32'd0, 32'd0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL illegal_opcode obs=%h", observed());
    end
    cycle(1'b1, 6'd0, 6'b100000, 32'd2, 32'd3, 16'd0, 1'b0, 1'b0);
    cycle(1'b0, 6'd0, 6'b100000, 32'd2, 32'd3, 16'd0, 1'b0, 1'b0);
    checks++;
    if (observed() !== BUBBLE) begin
      errors++; $display("FAIL illegal_then_bubble obs=%h", observed());
    end
    cycle(1'b1, 6'd0, 6'b111111, 32'd5, 32'd6, 16'd0, 1'b0, 1'b0);
    checks++;
    if (observed() !== {3'b000, 32'd0, 32'd0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL illegal_funct obs=%h", observed());
    end
`ifdef ALU_ISSUE_STATS_EN
    checks++;
    if (issue_count !== 32'd1 || illegal_count !== 16'd2) begin
      errors++; $display("FAIL stats_counts issue=%0d illegal=%0d exp=1/2", issue_count, illegal_count);
    end
`endif
  endtask

  task automatic test_random();
    logic [5:0] opcs [10] = '{6'd0, 6'd8, 6'd9, 6'd10, 6'd12, 6'd13, 6'd35, 6'd43, 6'd4, 6'd5};
    logic [5:0] fns  [7]  = '{6'h24, 6'h25, 6'h20, 6'h21, 6'h22, 6'h23, 6'h2A};
    logic [5:0] opc;
    logic [5:0] fn;
    for (int i = 0; i < 400; i++) begin
      opc = ($urandom_range(0, 7) == 0) ? 6'($urandom) : opcs[$urandom_range(0, 9)];
      if (opc == 6'd0 && $urandom_range(0, 3) != 0) opc = 6'd0;
      fn  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 6)];
      cycle($urandom_range(0, 3) != 0, opc, fn, $urandom, $urandom, 16'($urandom),
            $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
      checks++;
      if (observed() !== exp_q) begin
        errors++; $display("FAIL random_%0d obs=%h exp=%h", i, observed(), exp_q);
      end
    end
`ifdef ALU_ISSUE_STATS_EN
    checks++;
    if (issue_count !== 32'(n_iss) || illegal_count !== 16'(n_ill)) begin
      errors++; $display("FAIL random_counts issue=%0d/%0d illegal=%0d/%0d", issue_count, n_iss, illegal_count, n_ill);
    end
`endif
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_opcode = '0; in_funct = '0;
    in_rs = '0; in_rt = '0; in_imm = '0; stall = 1'b0; flush = 1'b0;
    test_reset();
    test_rtype_sub();
    test_extensions();
    test_stall();
    test_flush();
    test_illegal_stats();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX pipeline stage that drives the ALU's 3-bit opcode and operand interface. It is the producer end of that interface.
- Decodes the MIPS primary opcode and funct fields into the ALU operation code, and selects and extends operand B.
- Registers the result with stall (hold) and flush (bubble) control.
- Sits between the register-file read in decode and the ALU in execute.

Parameters:
- DW, 32, datapath width of operands; must be ≥ 16.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  decode stage presents a valid instruction this cycle.
- in_opcode  in  6  instruction bits [31:26].
- in_funct  in  6  instruction bits [5:0].
- in_rs  in  DW  register rs read data.
- in_rt  in  DW  register rt read data.
- in_imm  in  16  instruction bits [15:0].
- stall  in  1  hold the current output registers.
- flush  in  1  replace the next output with a bubble.
- alu_op  out  3  ALU operation: 000 and, 001 or, 010 add, 110 sub, 111 slt.
- alu_a  out  DW  ALU operand A.
- alu_b  out  DW  ALU operand B.
- out_valid  out  1  the registered instruction is real (not a bubble).
- illegal  out  1  the registered instruction had an unrecognised encoding.

Behaviour:
- Reset (asynchronous, any time, including mid-stall): alu_op=000, alu_a=0, alu_b=0, out_valid=0, illegal=0. Outputs are bubble state on the first edge after release.
- Registered outputs only; latency is exactly 1 cycle from inputs to outputs. No combinational path from any input to any output.
- Priority at each rising edge: flush > stall > load.
  - flush=1: load a bubble (all outputs as in reset), regardless of stall or in_valid.
  - flush=0, stall=1: all outputs hold their previous values bit-exact.
  - flush=0, stall=0, in_valid=0: load a bubble.
  - flush=0, stall=0, in_valid=1: load the decoded instruction and set out_valid=1.
- Decode, R-type (opcode 000000), by funct, with B = rt:
  - 100100 → and
  - 100101 → or
  - 100000 → add
  - 100001 → add
  - 100010 → sub
  - 100011 → sub
  - 101010 → slt
- Decode, I-type:
  - addi 001000 → add, B = sign-extended imm.
  - addiu 001001 → add, B = sign-extended imm.
  - slti 001010 → slt, B = sign-extended imm.
  - andi 001100 → and, B = zero-extended imm.
  - ori 001101 → or, B = zero-extended imm.
  - lw 100011 → add, B = sign-extended imm.
  - sw 101011 → add, B = sign-extended imm.
  - beq 000100 → sub, B = rt.
  - bne 000101 → sub, B = rt.
- alu_a = in_rs for every legal instruction.
- Extension widths:
  - Sign extension replicates imm[15] into bits DW-1..16.
  - Zero extension fills those bits with 0.
  - Example: imm=0xFFFF gives 0xFFFFFFFF signed and 0x0000FFFF zero-extended.
- Unrecognised opcode, or R-type with an unlisted funct:
  - illegal=1, out_valid=1, alu_op=000, alu_a=0, alu_b=0.
  - The downstream stage raises the exception.
- slt compare semantics belong to the ALU. This stage only passes the operands.
- A stall asserted on the same edge as in_valid drops the incoming instruction. Decode is responsible for holding its own inputs during a stall.

Optional Feature:
- Macro: ALU_ISSUE_STATS_EN.
- When defined, two extra outputs are added:
  - issue_count (32 bits): increments on each edge that loads out_valid=1 with illegal=0.
  - illegal_count (16 bits): increments on each edge that loads illegal=1.
- Both counters are cleared by reset and wrap modulo 2^N. They do not increment on stall holds, flushes or bubbles.
- When not defined, these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset then idle: assert reset mid-cycle with in_valid=1 → outputs zero immediately; after release with in_valid=0, out_valid stays 0.
- R-type sub: opcode=000000, funct=100010, rs=11, rt=7 → next cycle alu_op=110, alu_a=11, alu_b=7, out_valid=1, illegal=0.
- I-type extensions, rs=0x10, imm=0xFFFF:
  - addi → alu_op=010, alu_b=0xFFFFFFFF.
  - ori → alu_op=001, alu_b=0x0000FFFF.
  - slti → alu_op=111, alu_b=0xFFFFFFFF.
- Stall hold: load an and (funct 100100), then stall=1 for 3 cycles while inputs change → outputs unchanged for all 3 cycles; stall=0 → the new instruction appears the next cycle.
- Flush priority: flush=1 and stall=1 together with in_valid=1 → next cycle out_valid=0, alu_op=000, alu_a=0, alu_b=0.
- Illegal plus stats (ALU_ISSUE_STATS_EN defined): issue opcode=111111, then one add, then one bubble → illegal=1 with out_valid=1 for the first; final counts issue_count=1, illegal_count=1.
